// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit for the EX stage.
// Owns the HI/LO registers, runs mult/div one bit per cycle, and stalls
// conflicting md-class instructions while an operation is in flight.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  // acc_hi/acc_lo: partial product (mult) or remainder/quotient (div)
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  // opb: multiplicand magnitude (mult) or divisor magnitude (div)
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] rs_raw_q, rs_raw_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_div_q, zero_div_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  // Instruction decode
  logic             rtype, dec_mult, dec_div, dec_mthi, dec_mtlo, dec_md, dec_signed;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  // Datapath step / finish values
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod, prod_neg;

  // Decode the presented instruction and form operand magnitudes
  always_comb begin
    rtype      = start && (ALUOp == ALUOP_RTYPE);
    dec_mult   = rtype && ((funct == F_MULT) || (funct == F_MULTU));
    dec_div    = rtype && ((funct == F_DIV) || (funct == F_DIVU));
    dec_mthi   = rtype && (funct == F_MTHI);
    dec_mtlo   = rtype && (funct == F_MTLO);
    dec_md     = dec_mult || dec_div || dec_mthi || dec_mtlo ||
                 (rtype && ((funct == F_MFHI) || (funct == F_MFLO)));
    dec_signed = (funct == F_MULT) || (funct == F_DIV);
    rs_neg     = dec_signed && rs_val[WIDTH-1];
    rt_neg     = dec_signed && rt_val[WIDTH-1];
    rs_mag     = rs_neg ? ({WIDTH{1'b0}} - rs_val) : rs_val;
    rt_mag     = rt_neg ? ({WIDTH{1'b0}} - rt_val) : rt_val;
  end

  // One iteration of shift-add multiply and restoring divide, plus final product
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + ({1'b0, opb_q} & {(WIDTH+1){acc_lo_q[0]}});
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[WIDTH];
    prod      = {acc_hi_q, acc_lo_q};
    prod_neg  = {(2*WIDTH){1'b0}} - prod;
  end

  // Sequencer next-state, datapath and HI/LO update
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opb_d      = opb_q;
    rs_raw_d   = rs_raw_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    zero_div_d = zero_div_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (dec_mult || dec_div) begin
            state_d    = S_RUN;
            count_d    = '0;
            rs_raw_d   = rs_val;
            is_div_d   = dec_div;
            neg_res_d  = dec_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_rem_d  = dec_signed && rs_val[WIDTH-1];
            zero_div_d = dec_div && (rt_val == '0);
            acc_hi_d   = '0;
            if (dec_div) begin
              opb_d    = rt_mag;
              acc_lo_d = rs_mag;
            end else begin
              opb_d    = rs_mag;
              acc_lo_d = rt_mag;
            end
          end else if (dec_mthi) begin
            hi_d = rs_val;
          end else if (dec_mtlo) begin
            lo_d = rs_val;
          end
        end
      end

      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_hi_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          if (count_q == LAST_STEP) begin
            state_d = S_FIN;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (zero_div_q) begin
            hi_d  = rs_raw_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else if (is_div_q) begin
            lo_d = neg_res_q ? ({WIDTH{1'b0}} - acc_lo_q) : acc_lo_q;
            hi_d = neg_rem_q ? ({WIDTH{1'b0}} - acc_hi_q) : acc_hi_q;
          end else begin
            {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opb_q      <= '0;
      rs_raw_q   <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opb_q      <= opb_d;
      rs_raw_q   <= rs_raw_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      zero_div_q <= zero_div_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  // Status outputs; stall only holds md-class instructions
  always_comb begin
    busy        = (state_q != S_IDLE);
    stall       = busy && dec_md && !flush;
    done        = done_q;
    div_by_zero = dbz_q;
    hi          = hi_q;
    lo          = lo_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard testbench for muldiv_sequencer: directed cases plus a random
// stream of md-class and unrelated instructions against a 64-bit arithmetic model.
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  ALUOp = 3'b000;
  logic [5:0]  funct = 6'b000000;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [64:0] sb[$];          // {div_by_zero, hi, lo}
  logic [31:0] model_hi = '0;  // architectural HI/LO once all issued ops retire
  logic [31:0] model_lo = '0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUOp(ALUOp), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .busy(busy), .stall(stall),
    .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result computed with plain wide arithmetic
  function automatic logic [64:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb_, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ref_op = '0;
    case (f)
      F_MULT:  begin p = 64'(sa * sb_); ref_op = {1'b0, p}; end
      F_MULTU: begin p = {32'b0, a} * {32'b0, b}; ref_op = {1'b0, p}; end
      F_DIV, F_DIVU: begin
        if (b == 0) ref_op = {1'b1, a, 32'hFFFF_FFFF};
        else if (f == F_DIV) begin
          q = sa / sb_; r = sa % sb_;
          ref_op = {1'b0, r[31:0], q[31:0]};
        end else ref_op = {1'b0, a % b, a / b};
      end
      default: ref_op = '0;
    endcase
  endfunction

  // Present an md-class op, hold it while stalled, and record expectations.
  // Returns one cycle after acceptance (cycle T+1).
  task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int stalled);
    logic [64:0] e;
    stalled = 0;
    @(posedge clk); #1;
    start = 1'b1; ALUOp = 3'b010; funct = f; rs_val = a; rt_val = b; flush = 1'b0;
    while (busy && stalled < 100) begin
      #1;
      chk("stall_while_busy", {64'b0, stall}, 65'd1);
      @(posedge clk); #1;
      stalled++;
    end
    if (stalled >= 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: busy still high after %0d cycles", stalled);
    end
    #1;
    chk("stall_on_accept", {64'b0, stall}, 65'd0);
    if (f == F_MFHI) chk("mfhi_value", {33'b0, hi}, {33'b0, model_hi});
    if (f == F_MFLO) chk("mflo_value", {33'b0, lo}, {33'b0, model_lo});
    if (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU) begin
      e = ref_op(f, a, b);
      sb.push_back(e);
      model_hi = e[63:32];
      model_lo = e[31:0];
    end
    if (f == F_MTHI) model_hi = a;
    if (f == F_MTLO) model_lo = a;
    @(posedge clk); #1;
    start = 1'b0;
    if (f == F_MTHI) chk("mthi_write", {33'b0, hi}, {33'b0, a});
    if (f == F_MTLO) chk("mtlo_write", {33'b0, lo}, {33'b0, a});
    $display("txn funct=%b rs=%h rt=%h stalled=%0d", f, a, b, stalled);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 100) begin @(posedge clk); #1; g++; end
    if (g >= 100) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy stuck high");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compare each done pulse against the oldest expected result
  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got hi=%h lo=%h expected no done", hi, lo);
        end else begin
          e = sb.pop_front();
          chk("result", {div_by_zero, hi, lo}, e);
          $display("done dbz=%b hi=%h lo=%h", div_by_zero, hi, lo);
        end
      end else if (div_by_zero) begin
        checks++; errors++;
        $display("FAIL dbz_without_done: got 1 expected 0");
      end
    end
  end

  initial begin
    int st;
    int fsel;
    logic [5:0] fl [8];
    logic [31:0] a, b;
    fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", {59'b0, busy, stall, done, div_by_zero, 2'b0}, 65'd0);
    chk("reset_hilo", {1'b0, hi, lo}, 65'd0);
    rst = 1'b0;

    // mult 7 * -3 with exact latency check
    send(F_MULT, 32'd7, 32'hFFFF_FFFD, st);   // now in cycle T+1
    for (int k = 1; k <= 33; k++) begin
      chk("lat_busy", {63'b0, busy, done}, 65'b10);
      @(posedge clk); #1;
    end
    chk("lat_done", {63'b0, busy, done}, 65'b01);
    chk("lat_value", {1'b0, hi, lo}, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    @(posedge clk); #1;
    chk("done_one_cycle", {64'b0, done}, 65'd0);

    send(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
    send(F_DIV, 32'hFFFF_FFF9, 32'd2, st);
    send(F_DIVU, 32'd7, 32'd2, st);
    send(F_DIVU, 32'd5, 32'd0, st);
    send(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
    wait_idle();
    chk("overflow_div", {1'b0, hi, lo}, {1'b0, 32'd0, 32'h8000_0000});

    // mflo presented at T+5 of a mult and held until accepted
    send(F_MULT, 32'd1234, 32'hFFFF_0001, st);
    repeat (3) @(posedge clk);
    send(F_MFLO, 32'd0, 32'd0, st);
    chk("mflo_stall_cycles", {33'b0, 32'(st)}, 65'd29);

    // Non-md instructions, wrong ALUOp, and flushed md never stall
    send(F_DIVU, 32'd1000, 32'd7, st);
    @(posedge clk); #1;
    start = 1'b1; ALUOp = 3'b010; funct = F_ADD; #1;
    chk("add_no_stall", {64'b0, stall}, 65'd0);
    ALUOp = 3'b000; funct = F_MFLO; #1;
    chk("aluop_no_stall", {64'b0, stall}, 65'd0);
    ALUOp = 3'b010; flush = 1'b0; #1;
    chk("md_busy_stall", {64'b0, stall}, 65'd1);
    flush = 1'b1; #1;
    chk("flush_no_stall", {64'b0, stall}, 65'd0);
    flush = 1'b0; start = 1'b0;
    wait_idle();

    // Flush at T+10 of a div: idle at T+11, no done, hi/lo unchanged
    send(F_DIV, 32'd99, 32'd4, st);
    void'(sb.pop_back());
    model_hi = hi; model_lo = lo;
    repeat (9) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {64'b0, busy}, 65'd0);
    repeat (40) @(posedge clk); #1;
    chk("flush_hilo", {1'b0, hi, lo}, {1'b0, model_hi, model_lo});

    // Flush in IDLE wins over a presented mult and mthi
    @(posedge clk); #1;
    start = 1'b1; ALUOp = 3'b010; funct = F_MULT; rs_val = 32'd3; rt_val = 32'd3; flush = 1'b1;
    @(posedge clk); #1;
    funct = F_MTHI;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("idle_flush", {32'b0, busy, hi}, {32'b0, 1'b0, model_hi});

    send(F_MTHI, 32'h0000_1234, 32'd0, st);
    send(F_MTLO, 32'hCAFE_F00D, 32'd0, st);

    // Random stream, including back-to-back ops and unrelated instructions
    for (int n = 0; n < 50; n++) begin
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = $urandom_range(1, 9);
        default: ;
      endcase
      fsel = $urandom_range(0, 9);
      if (fsel > 7) begin
        @(posedge clk); #1;
        start = 1'b1; ALUOp = 3'($urandom_range(0, 7)); funct = F_ADD + 6'($urandom_range(0, 7));
        #1;
        chk("rand_other_stall", {64'b0, stall}, 65'd0);
        @(posedge clk); #1;
        start = 1'b0;
        $display("txn other aluop=%b funct=%b", ALUOp, funct);
      end else begin
        send(fl[fsel], a, b, st);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();

    // Reset mid-RUN clears everything immediately
    send(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, st);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_reset", {29'b0, busy, done, div_by_zero, hi, lo}, 65'd0);
    sb.delete();
    model_hi = '0; model_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk); #1;
    chk("post_reset_hilo", {1'b0, hi, lo}, 65'd0);

    chk("scoreboard_empty", {33'b0, 32'(sb.size())}, 65'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
